// File: rtl/split_pkg.sv
// Shared types and header field layout for the split feeder.
// Header: bit DEST_BIT selects the destination, LEN_MSB:LEN_LSB hold N-1.
package split_pkg;

    typedef enum logic {
        HDR = 1'b0,
        PAY = 1'b1
    } state_t;

    localparam int DEST_BIT = 0;
    localparam int LEN_LSB  = 1;
    localparam int LEN_MSB  = 4;
    localparam int CNT_W    = 16;

endpackage

// File: rtl/split_fifo.sv
// Small synchronous FIFO with registered full/empty flags.
// Head entry is presented directly from storage.
module split_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic [AW:0]      count_nx;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rptr];

    always_comb begin
        count_nx = count;
        case ({do_push, do_pop})
            2'b10:   count_nx = count + (AW+1)'(1);
            2'b01:   count_nx = count - (AW+1)'(1);
            default: count_nx = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            count <= count_nx;
            full  <= (count_nx == FULL_CNT);
            empty <= (count_nx == '0);
        end
    end

endmodule

// File: rtl/split_feeder.sv
// Parses header+payload packets and feeds {data, sel} words to a split
// stage through a small FIFO, counting deliveries per destination.
module split_feeder
    import split_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sel,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    localparam int RW = LEN_MSB - LEN_LSB + 2;

    state_t        state;
    state_t        state_nx;
    logic          dest;
    logic          dest_nx;
    logic [RW-1:0] rem;
    logic [RW-1:0] rem_nx;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [WIDTH:0] head;

    split_fifo #(
        .WIDTH (WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({in_data, dest}),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign out_valid = ~empty;
    assign out_data  = head[WIDTH:1];
    assign out_sel   = head[0];
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HDR;
            dest  <= 1'b0;
            rem   <= '0;
        end else begin
            state <= state_nx;
            dest  <= dest_nx;
            rem   <= rem_nx;
        end
    end

    // in_ready in PAY depends only on the registered full flag
    always_comb begin
        state_nx = state;
        dest_nx  = dest;
        rem_nx   = rem;
        push     = 1'b0;
        in_ready = 1'b1;
        unique case (state)
            HDR: begin
                if (in_valid) begin
                    dest_nx  = in_data[DEST_BIT];
                    rem_nx   = {1'b0, in_data[LEN_MSB:LEN_LSB]} + RW'(1);
                    state_nx = PAY;
                end
            end
            PAY: begin
                in_ready = ~full;
                if (in_valid && !full) begin
                    push   = 1'b1;
                    rem_nx = rem - RW'(1);
                    if (rem == RW'(1)) begin
                        state_nx = HDR;
                    end
                end
            end
            default: state_nx = HDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (pop) begin
            if (!out_sel && cnt0 != '1) begin
                cnt0 <= cnt0 + CNT_W'(1);
            end
            if (out_sel && cnt1 != '1) begin
                cnt1 <= cnt1 + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_split_feeder.sv
// Directed and random checks of split_feeder against a packet-level model.
// The model tracks expected words in a queue and delivery counts.
module tb_split_feeder;

    localparam int WIDTH = 8;
    localparam int DEPTH = 2;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_sel;
    logic [15:0]      cnt0;
    logic [15:0]      cnt1;

    split_feeder #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .cnt0      (cnt0),
        .cnt1      (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit rnd_on   = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Packet-level model: expected word queue, parse position, counters
    logic [WIDTH:0] q[$];
    bit             m_hdr;
    bit             m_dest;
    int             m_rem;
    int             m_cnt0;
    int             m_cnt1;
    bit             model_ok = 0;

    always @(negedge clk) begin
        bit exp_ov;
        bit exp_ir;
        logic [WIDTH:0] e;
        if (model_ok) begin
            exp_ov = (q.size() != 0);
            exp_ir = m_hdr || (q.size() < DEPTH);
            chk("out_valid", 32'(out_valid), 32'(exp_ov));
            chk("in_ready", 32'(in_ready), 32'(exp_ir));
            if (exp_ov) begin
                e = q[0];
                chk("out_data", 32'(out_data), 32'(e[WIDTH:1]));
                chk("out_sel", 32'(out_sel), 32'(e[0]));
            end
            chk("cnt0", 32'(cnt0), 32'(m_cnt0));
            chk("cnt1", 32'(cnt1), 32'(m_cnt1));
        end
        if (rst) begin
            q.delete();
            m_hdr    = 1;
            m_dest   = 0;
            m_rem    = 0;
            m_cnt0   = 0;
            m_cnt1   = 0;
            model_ok = 1;
        end else if (model_ok) begin
            exp_ov = (q.size() != 0);
            exp_ir = m_hdr || (q.size() < DEPTH);
            if (exp_ov && out_ready) begin
                e = q.pop_front();
                if (e[0]) begin
                    if (m_cnt1 < 65535) m_cnt1++;
                end else begin
                    if (m_cnt0 < 65535) m_cnt0++;
                end
            end
            if (in_valid && exp_ir) begin
                if (m_hdr) begin
                    m_dest = in_data[0];
                    m_rem  = int'(in_data[4:1]) + 1;
                    m_hdr  = 0;
                end else begin
                    q.push_back({in_data, m_dest});
                    m_rem--;
                    if (m_rem == 0) m_hdr = 1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rnd_on) out_ready = ($urandom_range(0, 7) != 0);
    endtask

    task automatic sendw(input logic [7:0] w, output int waits);
        bit done;
        in_valid = 1'b1;
        in_data  = w;
        waits    = 0;
        done     = 0;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1;
                step();
            end else begin
                step();
                waits++;
                if (waits > 200) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL send_timeout: got %0d waits expected <=200", waits);
                    done = 1;
                end
            end
        end
    endtask

    task automatic send(input logic [7:0] w);
        int d;
        sendw(w, d);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        int w;
        int n;
        logic [7:0] h;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_sel", 32'(out_sel), 32'd0);
        chk("rst_cnt0", 32'(cnt0), 32'd0);
        chk("rst_cnt1", 32'(cnt1), 32'd0);

        // single packet, dest1, N=2
        send(8'h03);
        send(8'hA5);
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_data0", 32'(out_data), 32'hA5);
        chk("t1_sel0", 32'(out_sel), 32'd1);
        send(8'h5A);
        chk("t1_data1", 32'(out_data), 32'h5A);
        chk("t1_sel1", 32'(out_sel), 32'd1);
        idle(3);
        chk("t1_cnt1", 32'(cnt1), 32'd2);
        chk("t1_cnt0", 32'(cnt0), 32'd0);

        // backpressure, dest0, N=16
        out_ready = 1'b0;
        send(8'h1E);
        send(8'h00);
        send(8'h01);
        chk("t2_in_ready", 32'(in_ready), 32'd0);
        chk("t2_head", 32'(out_data), 32'h00);
        out_ready = 1'b1;
        for (int i = 2; i < 16; i++) send(8'(i));
        idle(4);
        chk("t2_cnt0", 32'(cnt0), 32'd16);

        // back-to-back packets
        send(8'h00);
        send(8'h11);
        chk("t3_data0", 32'(out_data), 32'h11);
        chk("t3_sel0", 32'(out_sel), 32'd0);
        sendw(8'h01, w);
        chk("t3_hdr_wait", 32'(w), 32'd0);
        send(8'h22);
        chk("t3_data1", 32'(out_data), 32'h22);
        chk("t3_sel1", 32'(out_sel), 32'd1);
        idle(3);
        chk("t3_cnt1", 32'(cnt1), 32'd3);
        chk("t3_cnt0", 32'(cnt0), 32'd17);

        // reset mid-packet
        out_ready = 1'b0;
        send(8'h07);
        send(8'h0A);
        send(8'h0B);
        chk("t4_pre_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t4_valid", 32'(out_valid), 32'd0);
        chk("t4_in_ready", 32'(in_ready), 32'd1);
        chk("t4_cnt0", 32'(cnt0), 32'd0);
        chk("t4_cnt1", 32'(cnt1), 32'd0);
        out_ready = 1'b1;
        send(8'h01);
        send(8'h3C);
        chk("t4_data", 32'(out_data), 32'h3C);
        chk("t4_sel", 32'(out_sel), 32'd1);
        idle(3);
        chk("t4_cnt1", 32'(cnt1), 32'd1);

        // saturation: 4096 x 16 sel0 deliveries
        for (int p = 0; p < 4096; p++) begin
            send(8'h1E);
            for (int i = 0; i < 16; i++) send(8'($urandom));
        end
        idle(4);
        chk("t5_cnt0_sat", 32'(cnt0), 32'hFFFF);
        chk("t5_cnt1", 32'(cnt1), 32'd1);

        // random stress
        rnd_on = 1;
        for (int p = 0; p < 1000; p++) begin
            n = $urandom_range(1, 16);
            h = {3'($urandom), 4'(n - 1), 1'($urandom)};
            send(h);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 7) == 0) idle(1);
                send(8'($urandom));
            end
        end
        rnd_on = 0;
        out_ready = 1'b1;
        in_valid = 1'b0;
        w = 0;
        while (q.size() != 0 && w < 100) begin
            step();
            w++;
        end
        step();
        chk("t6_drained", 32'(q.size()), 32'd0);
        chk("t6_valid", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
